// File: rtl/bsg_arb_rr_packet_lock.sv
// Packet-locking round-robin arbiter: one multi-beat packet at a time wins the
// shared output channel, and priority rotates only when a packet's last beat leaves.
`timescale 1ns/1ps

module bsg_arb_rr_packet_lock #(
    parameter  int width_p      = 4,
    parameter  int data_width_p = 32,
    localparam int lg_width_lp  = (width_p > 1) ? $clog2(width_p) : 1
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic [width_p-1:0]                v_i,
    input  logic [width_p*data_width_p-1:0]   data_i,
    input  logic [width_p-1:0]                last_i,
    output logic [width_p-1:0]                yumi_o,
    output logic                              v_o,
    output logic [data_width_p-1:0]           data_o,
    output logic                              last_o,
    input  logic                              ready_i,
    output logic                              locked_o,
    output logic [lg_width_lp-1:0]            owner_o
);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_e;

    state_e                  state_r;
    logic [lg_width_lp-1:0]  owner_r;
    logic [lg_width_lp-1:0]  last_gnt_r;

    logic [lg_width_lp-1:0]  sel;
    logic [lg_width_lp-1:0]  cur;
    logic                    cur_v;
    logic                    cur_last;
    logic [data_width_p-1:0] cur_data;
    logic                    xfer;

    // Rank 0 is the requester just below the last winner; the last winner itself
    // ranks lowest, so the lowest-ranked valid requester wins.
    always_comb begin
        int rank;
        int best;
        sel  = '0;
        best = width_p;
        rank = 0;
        for (int k = 0; k < width_p; k++) begin
            rank = (int'(last_gnt_r) - 1 - k + 2 * width_p) % width_p;
            if (v_i[k] && (rank < best)) begin
                best = rank;
                sel  = lg_width_lp'(k);
            end
        end
    end

    assign cur = (state_r == LOCKED) ? owner_r : sel;

    always_comb begin
        cur_v    = 1'b0;
        cur_last = 1'b0;
        cur_data = '0;
        for (int k = 0; k < width_p; k++) begin
            if (cur == lg_width_lp'(k)) begin
                cur_v    = v_i[k];
                cur_last = last_i[k];
                cur_data = data_i[k*data_width_p +: data_width_p];
            end
        end
    end

    assign v_o    = ~reset_i & ((state_r == LOCKED) ? cur_v : (|v_i));
    assign data_o = cur_data;
    assign last_o = cur_last;
    assign xfer   = v_o & ready_i;

    always_comb begin
        yumi_o = '0;
        for (int k = 0; k < width_p; k++) begin
            yumi_o[k] = xfer & (cur == lg_width_lp'(k));
        end
    end

    assign locked_o = ~reset_i & (state_r == LOCKED);
    assign owner_o  = reset_i ? '0 : owner_r;

    // Priority (last_gnt_r) moves only on a final beat, never on a middle beat.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r    <= IDLE;
            owner_r    <= '0;
            last_gnt_r <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (xfer) begin
                        if (cur_last) begin
                            last_gnt_r <= sel;
                        end else begin
                            state_r <= LOCKED;
                            owner_r <= sel;
                        end
                    end
                end
                LOCKED: begin
                    if (xfer && cur_last) begin
                        state_r    <= IDLE;
                        last_gnt_r <= owner_r;
                        owner_r    <= '0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    owner_r <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bsg_arb_rr_packet_lock.sv
// Bench for bsg_arb_rr_packet_lock: directed scenarios with literal expectations,
// then random traffic checked every cycle against a behavioural arbiter model.
`timescale 1ns/1ps

module tb_bsg_arb_rr_packet_lock;

    localparam int W  = 4;
    localparam int DW = 32;
    localparam int LW = 2;

    logic            clk = 1'b0;
    logic            reset_i;
    logic [W-1:0]    v_i;
    logic [W*DW-1:0] data_i;
    logic [W-1:0]    last_i;
    logic [W-1:0]    yumi_o;
    logic            v_o;
    logic [DW-1:0]   data_o;
    logic            last_o;
    logic            ready_i;
    logic            locked_o;
    logic [LW-1:0]   owner_o;

    always #5 clk = ~clk;

    bsg_arb_rr_packet_lock #(.width_p(W), .data_width_p(DW)) dut (
        .clk_i    (clk),
        .reset_i  (reset_i),
        .v_i      (v_i),
        .data_i   (data_i),
        .last_i   (last_i),
        .yumi_o   (yumi_o),
        .v_o      (v_o),
        .data_o   (data_o),
        .last_o   (last_o),
        .ready_i  (ready_i),
        .locked_o (locked_o),
        .owner_o  (owner_o)
    );

    int checks = 0;
    int errors = 0;

    // requester sources: packet length, beat index, packet sequence number
    int plen[W];
    int bidx[W];
    int pseq[W];
    bit rand_len = 0;

    // model: current packet owner (if any) and owner of the last finished packet
    bit m_locked;
    int m_owner;
    int m_last;

    bit           e_v;
    int           e_cur;
    logic [W-1:0] e_yumi;

    bit t_busy;
    int t_req;
    int t_beat;
    int loss[W];

    task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] beat_word(input int k);
        return {8'(k), 8'(pseq[k]), 16'(bidx[k])};
    endfunction

    task automatic apply_stimulus(input logic rst, input logic [W-1:0] v, input logic rdy);
        reset_i = rst;
        v_i     = v;
        ready_i = rdy;
        for (int k = 0; k < W; k++) begin
            data_i[k*DW +: DW] = beat_word(k);
            last_i[k]          = (bidx[k] == plen[k] - 1);
        end
        #2;
    endtask

    task automatic check_output();
        e_yumi = '0;
        e_v    = 1'b0;
        e_cur  = 0;
        if (!reset_i) begin
            if (m_locked) begin
                e_cur = m_owner;
                e_v   = v_i[m_owner];
            end else begin
                for (int i = 1; i <= W; i++) begin
                    int idx;
                    idx = (m_last - i + W) % W;
                    if (v_i[idx]) begin
                        e_cur = idx;
                        e_v   = 1'b1;
                        break;
                    end
                end
            end
            if (e_v && ready_i) e_yumi[e_cur] = 1'b1;
        end
        check_val("v_o", v_o, e_v);
        check_val("yumi_o", yumi_o, e_yumi);
        check_val("locked_o", locked_o, !reset_i && m_locked);
        check_val("owner_o", owner_o, (!reset_i && m_locked) ? m_owner : 0);
        if (e_v) begin
            check_val("data_o", data_o, beat_word(e_cur));
            check_val("last_o", last_o, last_i[e_cur]);
        end
        check_val("yumi_onehot", $countones(yumi_o) <= 1, 1);
        check_val("yumi_needs_ready", (yumi_o != 0) && !ready_i, 0);

        // output stream must never interleave beats of different packets
        if (v_o && ready_i && !reset_i) begin
            if (t_busy) begin
                check_val("pkt_req", data_o[31:24], t_req);
                check_val("pkt_beat", data_o[15:0], t_beat);
            end else begin
                check_val("pkt_start", data_o[15:0], 0);
            end
            if (last_o) begin
                t_busy = 1'b0;
            end else begin
                t_busy = 1'b1;
                t_req  = int'(data_o[31:24]);
                t_beat = int'(data_o[15:0]) + 1;
            end
        end

        // a continuously waiting requester may lose at most W-1 arbitrations
        if (!reset_i && !m_locked) begin
            for (int k = 0; k < W; k++) begin
                if (!v_i[k] || yumi_o[k]) begin
                    loss[k] = 0;
                end else if (yumi_o != 0) begin
                    loss[k]++;
                    check_val("starvation", loss[k] <= W - 1, 1);
                end
            end
        end
    endtask

    task automatic finish_cycle();
        if (reset_i) begin
            m_locked = 1'b0;
            m_owner  = 0;
            m_last   = 0;
            t_busy   = 1'b0;
            for (int k = 0; k < W; k++) begin
                bidx[k] = 0;
                loss[k] = 0;
            end
        end else if (e_yumi != 0) begin
            if (last_i[e_cur]) begin
                m_locked = 1'b0;
                m_owner  = 0;
                m_last   = e_cur;
                bidx[e_cur] = 0;
                pseq[e_cur]++;
                if (rand_len) plen[e_cur] = $urandom_range(1, 4);
            end else begin
                m_locked = 1'b1;
                m_owner  = e_cur;
                bidx[e_cur]++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cycle(input logic rst, input logic [W-1:0] v, input logic rdy);
        apply_stimulus(rst, v, rdy);
        check_output();
        finish_cycle();
    endtask

    task automatic set_lens(input int l0, input int l1, input int l2, input int l3);
        plen[0] = l0;
        plen[1] = l1;
        plen[2] = l2;
        plen[3] = l3;
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        logic [W-1:0] t1_yumi [5];
        logic [W-1:0] t2_yumi [5];
        logic         t2_lock [5];
        logic [LW-1:0] t2_own [5];
        logic         t3_rdy  [8];
        logic [W-1:0] t3_yumi [8];
        logic [W-1:0] t4_v    [6];
        logic [W-1:0] t4_yumi [6];
        logic         t4_vo   [6];
        logic         t4_lock [6];

        t1_yumi = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000};
        t2_yumi = '{4'b0100, 4'b0010, 4'b0010, 4'b0010, 4'b0100};
        t2_lock = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        t2_own  = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd0};
        t3_rdy  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        t3_yumi = '{4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0001, 4'b1000};
        t4_v    = '{4'b1010, 4'b0010, 4'b0010, 4'b1010, 4'b1010, 4'b1010};
        t4_yumi = '{4'b1000, 4'b0000, 4'b0000, 4'b1000, 4'b1000, 4'b0010};
        t4_vo   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        t4_lock = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

        for (int k = 0; k < W; k++) begin
            plen[k] = 1;
            bidx[k] = 0;
            pseq[k] = 0;
            loss[k] = 0;
        end
        m_locked = 1'b0;
        m_owner  = 0;
        m_last   = 0;
        t_busy   = 1'b0;
        t_req    = 0;
        t_beat   = 0;
        reset_i  = 1'b1;
        v_i      = '0;
        last_i   = '0;
        data_i   = '0;
        ready_i  = 1'b0;
        @(posedge clk);
        #1;

        // reset holds every output low even with requests pending
        apply_stimulus(1'b1, 4'hF, 1'b1);
        check_output();
        check_val("reset_v_o", v_o, 0);
        check_val("reset_yumi", yumi_o, 0);
        finish_cycle();

        // all four send single-beat packets back to back
        set_lens(1, 1, 1, 1);
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(1'b0, 4'hF, 1'b1);
            check_output();
            check_val("t1_rr_yumi", yumi_o, t1_yumi[i]);
            finish_cycle();
        end

        // req 2 single beat wins first, then req 1 locks for three beats
        cycle(1'b1, 4'h0, 1'b1);
        set_lens(1, 3, 1, 1);
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(1'b0, 4'b0110, 1'b1);
            check_output();
            check_val("t2_yumi", yumi_o, t2_yumi[i]);
            check_val("t2_locked", locked_o, t2_lock[i]);
            check_val("t2_owner", owner_o, t2_own[i]);
            finish_cycle();
        end

        // req 0 locked while ready toggles and everyone else requests
        cycle(1'b1, 4'h0, 1'b1);
        set_lens(4, 1, 1, 1);
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(1'b0, (i == 0) ? 4'b0001 : 4'b1111, t3_rdy[i]);
            check_output();
            check_val("t3_yumi", yumi_o, t3_yumi[i]);
            finish_cycle();
        end

        // owner 3 bubbles for two cycles; req 1 must wait
        cycle(1'b1, 4'h0, 1'b1);
        set_lens(1, 1, 1, 3);
        for (int i = 0; i < 6; i++) begin
            apply_stimulus(1'b0, t4_v[i], 1'b1);
            check_output();
            check_val("t4_yumi", yumi_o, t4_yumi[i]);
            check_val("t4_v_o", v_o, t4_vo[i]);
            check_val("t4_locked", locked_o, t4_lock[i]);
            finish_cycle();
        end

        // reset during beat 2 of a 4-beat packet from req 2
        cycle(1'b1, 4'h0, 1'b1);
        set_lens(1, 1, 4, 1);
        cycle(1'b0, 4'b0100, 1'b1);
        apply_stimulus(1'b0, 4'b0100, 1'b1);
        check_output();
        check_val("t5_locked_mid", locked_o, 1);
        check_val("t5_owner_mid", owner_o, 2);
        finish_cycle();
        apply_stimulus(1'b1, 4'b0100, 1'b1);
        check_output();
        check_val("t5_rst_v_o", v_o, 0);
        check_val("t5_rst_yumi", yumi_o, 0);
        check_val("t5_rst_locked", locked_o, 0);
        check_val("t5_rst_owner", owner_o, 0);
        finish_cycle();
        apply_stimulus(1'b0, 4'b1001, 1'b1);
        check_output();
        check_val("t5_after_yumi", yumi_o, 4'b1000);
        check_val("t5_after_locked", locked_o, 0);
        finish_cycle();

        // random traffic
        cycle(1'b1, 4'h0, 1'b1);
        rand_len = 1'b1;
        for (int k = 0; k < W; k++) plen[k] = $urandom_range(1, 4);
        for (int n = 0; n < 3000; n++) begin
            logic [W-1:0] rv;
            for (int k = 0; k < W; k++) rv[k] = ($urandom_range(0, 9) < 7);
            cycle($urandom_range(0, 499) == 0, rv, $urandom_range(0, 3) != 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
